fetch1_stage: RTL and testbench

- First front-end stage. Generates the fetch PC and issues aligned block requests to the instruction cache over a req/ack handshake.
- Hands each returned fetch block to fetch stage 2.
- Honours fetch1Stall_o from the pipeline stall unit, and takes branch/exception redirects from the back end.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch1_pc_gen.sv | 75 +++++++
 rtl/fetch1_stage.sv | 185 ++++++++++++++++++
 tb/tb_fetch1_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end.
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 32;
    localparam int FETCH_BYTES_DEF = 16;
    localparam int FETCH_OFFSET_W  = $clog2(FETCH_BYTES_DEF);
    localparam int ALIGN_W         = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch1_state_e;

    // Clear the low off_w bits so the address points at the start of its block.
    function automatic logic [ALIGN_W-1:0] align_addr(input logic [ALIGN_W-1:0] addr,
                                                      input int unsigned off_w);
        return addr & ({ALIGN_W{1'b1}} << off_w);
    endfunction

endpackage

// File: rtl/fetch1_pc_gen.sv
// Fetch PC generator: block PC, first-byte offset and the discard flag
// for a request that was overtaken by a redirect.
module fetch1_pc_gen
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int                    FETCH_BYTES  = FETCH_BYTES_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           advance,
    input  logic                           redirect,
    input  logic [ADDR_WIDTH-1:0]          redirect_addr,
    input  logic                           set_discard,
    input  logic                           clr_discard,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [$clog2(FETCH_BYTES)-1:0] offset,
    output logic                           discard,
    output logic [ADDR_WIDTH-1:0]          pc_next
);

    localparam int OFF_W = $clog2(FETCH_BYTES);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [OFF_W-1:0]      offset_r;
    logic                  discard_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [OFF_W-1:0]      offset_next_s;
    logic                  discard_next_s;

    // Next PC/offset/discard: a redirect overrides any advance in the same cycle.
    always_comb begin
        pc_next_s      = pc_r;
        offset_next_s  = offset_r;
        discard_next_s = discard_r;
        if (redirect) begin
            pc_next_s      = ADDR_WIDTH'(align_addr(ALIGN_W'(redirect_addr), OFF_W));
            offset_next_s  = redirect_addr[OFF_W-1:0];
            discard_next_s = set_discard;
        end else begin
            if (advance) begin
                pc_next_s     = pc_r + ADDR_WIDTH'(FETCH_BYTES);
                offset_next_s = {OFF_W{1'b0}};
            end else begin
                pc_next_s     = pc_r;
                offset_next_s = offset_r;
            end
            if (clr_discard) begin
                discard_next_s = 1'b0;
            end else begin
                discard_next_s = discard_r;
            end
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_VECTOR;
            offset_r  <= {OFF_W{1'b0}};
            discard_r <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            offset_r  <= offset_next_s;
            discard_r <= discard_next_s;
        end
    end

    assign pc      = pc_r;
    assign offset  = offset_r;
    assign discard = discard_r;
    assign pc_next = pc_next_s;

endmodule

// File: rtl/fetch1_stage.sv
// Fetch stage 1: issues aligned block requests to the I-cache and presents
// returned blocks to fetch2. Optional counters: define FETCH1_PERF_CNT_EN.
module fetch1_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int                    FETCH_BYTES  = FETCH_BYTES_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h0000_0000)
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           stall_i,
    input  logic                           redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]          redirect_addr_i,
    output logic                           icache_req_o,
    output logic [ADDR_WIDTH-1:0]          icache_addr_o,
    input  logic                           icache_ack_i,
    input  logic [FETCH_BYTES*8-1:0]       icache_data_i,
    output logic                           fetch_valid_o,
    output logic [ADDR_WIDTH-1:0]          fetch_pc_o,
    output logic [$clog2(FETCH_BYTES)-1:0] fetch_offset_o,
    output logic [FETCH_BYTES*8-1:0]       fetch_data_o
`ifdef FETCH1_PERF_CNT_EN
    , output logic [31:0]                  perf_stall_cycles_o
    , output logic [31:0]                  perf_discards_o
`endif
);

    localparam int OFF_W  = $clog2(FETCH_BYTES);
    localparam int DATA_W = FETCH_BYTES * 8;

    fetch1_state_e         state_r;
    fetch1_state_e         state_next_s;
    logic                  advance_s;
    logic                  redir_s;
    logic                  set_discard_s;
    logic                  clr_discard_s;
    logic                  capture_s;
    logic                  drop_s;
    logic                  load_addr_s;
    logic                  valid_next_s;
    logic [ADDR_WIDTH-1:0] pc_s;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [OFF_W-1:0]      offset_s;
    logic                  discard_s;

    fetch1_pc_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .FETCH_BYTES  (FETCH_BYTES),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_gen (
        .clk           (clock_i),
        .rst_n         (reset_i),
        .advance       (advance_s),
        .redirect      (redir_s),
        .redirect_addr (redirect_addr_i),
        .set_discard   (set_discard_s),
        .clr_discard   (clr_discard_s),
        .pc            (pc_s),
        .offset        (offset_s),
        .discard       (discard_s),
        .pc_next       (pc_next_s)
    );

    // Next-state and control decode; a stalled output register keeps its valid.
    always_comb begin
        state_next_s  = state_r;
        advance_s     = 1'b0;
        redir_s       = 1'b0;
        set_discard_s = 1'b0;
        clr_discard_s = 1'b0;
        capture_s     = 1'b0;
        drop_s        = 1'b0;
        load_addr_s   = 1'b0;
        valid_next_s  = stall_i ? fetch_valid_o : 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_REQ;
                load_addr_s  = 1'b1;
            end
            ST_REQ: begin
                if (redirect_valid_i) begin
                    // The cache address stays put while the old request is in flight.
                    redir_s       = 1'b1;
                    set_discard_s = ~icache_ack_i;
                    drop_s        = icache_ack_i;
                    load_addr_s   = icache_ack_i;
                    valid_next_s  = 1'b0;
                end else if (icache_ack_i) begin
                    if (discard_s) begin
                        drop_s        = 1'b1;
                        clr_discard_s = 1'b1;
                        load_addr_s   = 1'b1;
                    end else begin
                        capture_s    = 1'b1;
                        valid_next_s = 1'b1;
                        if (stall_i) begin
                            state_next_s = ST_HOLD;
                        end else begin
                            advance_s   = 1'b1;
                            load_addr_s = 1'b1;
                        end
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    redir_s      = 1'b1;
                    valid_next_s = 1'b0;
                    state_next_s = ST_REQ;
                    load_addr_s  = 1'b1;
                end else if (!stall_i) begin
                    advance_s    = 1'b1;
                    valid_next_s = 1'b0;
                    state_next_s = ST_REQ;
                    load_addr_s  = 1'b1;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State and cache request registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r       <= ST_IDLE;
            icache_req_o  <= 1'b0;
            icache_addr_o <= RESET_VECTOR;
        end else begin
            state_r       <= state_next_s;
            icache_req_o  <= (state_next_s == ST_REQ);
            icache_addr_o <= load_addr_s ? pc_next_s : icache_addr_o;
        end
    end

    // Output register towards fetch2.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_valid_o  <= 1'b0;
            fetch_pc_o     <= {ADDR_WIDTH{1'b0}};
            fetch_offset_o <= {OFF_W{1'b0}};
            fetch_data_o   <= {DATA_W{1'b0}};
        end else begin
            fetch_valid_o <= valid_next_s;
            if (capture_s) begin
                fetch_pc_o     <= pc_s;
                fetch_offset_o <= offset_s;
                fetch_data_o   <= icache_data_i;
            end else begin
                fetch_pc_o     <= fetch_pc_o;
                fetch_offset_o <= fetch_offset_o;
                fetch_data_o   <= fetch_data_o;
            end
        end
    end

`ifdef FETCH1_PERF_CNT_EN
    // Saturating counters for HOLD cycles and dropped acks.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_stall_cycles_o <= 32'd0;
            perf_discards_o     <= 32'd0;
        end else begin
            if ((state_r == ST_HOLD) && (perf_stall_cycles_o != {32{1'b1}})) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end else begin
                perf_stall_cycles_o <= perf_stall_cycles_o;
            end
            if (drop_s && (perf_discards_o != {32{1'b1}})) begin
                perf_discards_o <= perf_discards_o + 32'd1;
            end else begin
                perf_discards_o <= perf_discards_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch1_stage.sv
// Directed bench for fetch1_stage with a small latency-programmable I-cache responder.
module tb_fetch1_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic         redir = 1'b0;
    logic [31:0]  raddr = 32'h0;
    logic         req;
    logic [31:0]  addr;
    logic         ack = 1'b0;
    logic [127:0] cdata = 128'h0;
    logic         valid;
    logic [31:0]  fpc;
    logic [3:0]   foff;
    logic [127:0] fdata;
`ifdef FETCH1_PERF_CNT_EN
    logic [31:0]  perf_stall;
    logic [31:0]  perf_disc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cnt     = 0;

    always #5 clk = ~clk;

    fetch1_stage #(
        .ADDR_WIDTH   (32),
        .FETCH_BYTES  (16),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clock_i          (clk),
        .reset_i          (rst_n),
        .stall_i          (stall),
        .redirect_valid_i (redir),
        .redirect_addr_i  (raddr),
        .icache_req_o     (req),
        .icache_addr_o    (addr),
        .icache_ack_i     (ack),
        .icache_data_i    (cdata),
        .fetch_valid_o    (valid),
        .fetch_pc_o       (fpc),
        .fetch_offset_o   (foff),
        .fetch_data_o     (fdata)
`ifdef FETCH1_PERF_CNT_EN
        , .perf_stall_cycles_o (perf_stall)
        , .perf_discards_o     (perf_disc)
`endif
    );

    function automatic logic [127:0] blk(input logic [31:0] a);
        return {a ^ 32'h3333_3333, a ^ 32'h2222_2222, a ^ 32'h1111_1111, a};
    endfunction

    // Cache: ack arrives `lat` cycles after a request first becomes visible.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !req) begin
                ack = 1'b0;
                cnt = 0;
            end else if (ack) begin
                ack = 1'b0;
                cnt = 1;
            end else if (cnt >= lat) begin
                ack   = 1'b1;
                cdata = blk(addr);
            end else begin
                cnt = cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input logic [31:0] exp_addr);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack && k < 30);
        check({tag, "_ack"}, 128'(ack), 128'(1'b1));
        check({tag, "_addr"}, 128'(addr), 128'(exp_addr));
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [3:0] off);
        check({tag, "_valid"}, 128'(valid), 128'(v));
        check({tag, "_pc"}, 128'(fpc), 128'(pc));
        check({tag, "_off"}, 128'(foff), 128'(off));
        check({tag, "_data"}, fdata, blk(pc));
    endtask

    initial begin
        repeat (2) step();
        check("rst_req", 128'(req), 128'(1'b0));
        check("rst_valid", 128'(valid), 128'(1'b0));
        check("rst_pc", 128'(fpc), 128'(32'h0));
        check("rst_off", 128'(foff), 128'(4'h0));
        check("rst_data", fdata, 128'h0);
        rst_n = 1'b1;

        // Sequential stream with a 1-cycle cache.
        wait_ack("b00", 32'h0000_0000);
        step();
        check_out("o00", 1'b1, 32'h0000_0000, 4'h0);
        check("req10", 128'(addr), 128'(32'h0000_0010));
        wait_ack("b10", 32'h0000_0010);
        check("pulse_end", 128'(valid), 128'(1'b0));
        stall = 1'b1;

        // Stall from the ack of 0x10 for three cycles.
        step();
        check_out("hold1", 1'b1, 32'h0000_0010, 4'h0);
        check("hold1_req", 128'(req), 128'(1'b0));
        step();
        check_out("hold2", 1'b1, 32'h0000_0010, 4'h0);
        step();
        stall = 1'b0;
        check_out("hold3", 1'b1, 32'h0000_0010, 4'h0);
        check("hold3_req", 128'(req), 128'(1'b0));
        step();
        check("resume_req", 128'(req), 128'(1'b1));
        check("resume_addr", 128'(addr), 128'(32'h0000_0020));
        check("resume_valid", 128'(valid), 128'(1'b0));
        wait_ack("b20", 32'h0000_0020);
        step();
        check_out("o20", 1'b1, 32'h0000_0020, 4'h0);
        wait_ack("b30", 32'h0000_0030);
        lat = 3;

        // Redirect while 0x40 is outstanding.
        step();
        check_out("o30", 1'b1, 32'h0000_0030, 4'h0);
        check("req40", 128'(addr), 128'(32'h0000_0040));
        step();
        redir = 1'b1;
        raddr = 32'h0000_1236;
        step();
        redir = 1'b0;
        check("rd_valid_clr", 128'(valid), 128'(1'b0));
        check("rd_addr_held", 128'(addr), 128'(32'h0000_0040));
        step();
        check("rd_old_ack", 128'(ack), 128'(1'b1));
        check("rd_old_addr", 128'(addr), 128'(32'h0000_0040));
        lat = 1;
        step();
        check("rd_dropped", 128'(valid), 128'(1'b0));
        check("rd_new_addr", 128'(addr), 128'(32'h0000_1230));
        wait_ack("b1230", 32'h0000_1230);
        step();
        check_out("o1230", 1'b1, 32'h0000_1230, 4'h6);
        check("req1240", 128'(addr), 128'(32'h0000_1240));

        // Redirect in the same cycle as an ack.
        wait_ack("b1240", 32'h0000_1240);
        redir = 1'b1;
        raddr = 32'h0000_2008;
        step();
        redir = 1'b0;
        check("ra_valid", 128'(valid), 128'(1'b0));
        check("ra_addr", 128'(addr), 128'(32'h0000_2000));
        wait_ack("b2000", 32'h0000_2000);
        step();
        check_out("o2000", 1'b1, 32'h0000_2000, 4'h8);

        // Redirect near the top of the address space, then wrap.
        redir = 1'b1;
        raddr = 32'hFFFF_FFF4;
        step();
        redir = 1'b0;
        check("wr_valid", 128'(valid), 128'(1'b0));
        check("wr_old_addr", 128'(addr), 128'(32'h0000_2010));
        step();
        check("wr_dropped", 128'(valid), 128'(1'b0));
        check("wr_new_addr", 128'(addr), 128'(32'hFFFF_FFF0));
        wait_ack("btop", 32'hFFFF_FFF0);
        step();
        check_out("otop", 1'b1, 32'hFFFF_FFF0, 4'h4);
        check("wrap_addr", 128'(addr), 128'(32'h0000_0000));

        // Reset while a request is pending.
        rst_n = 1'b0;
        #1;
        check("mr_req", 128'(req), 128'(1'b0));
        check("mr_valid", 128'(valid), 128'(1'b0));
        check("mr_pc", 128'(fpc), 128'(32'h0));
        check("mr_off", 128'(foff), 128'(4'h0));
        check("mr_data", fdata, 128'h0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_ack("rb00", 32'h0000_0000);
        step();
        check_out("ro00", 1'b1, 32'h0000_0000, 4'h0);

        // Redirect while held in HOLD with stall still high.
        wait_ack("rb10", 32'h0000_0010);
        stall = 1'b1;
        step();
        check_out("rh", 1'b1, 32'h0000_0010, 4'h0);
        redir = 1'b1;
        raddr = 32'h0000_3004;
        step();
        redir = 1'b0;
        stall = 1'b0;
        check("rh_req", 128'(req), 128'(1'b1));
        check("rh_addr", 128'(addr), 128'(32'h0000_3000));
        check("rh_valid", 128'(valid), 128'(1'b0));
        wait_ack("b3000", 32'h0000_3000);
        step();
        check_out("o3000", 1'b1, 32'h0000_3000, 4'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
